// File: rtl/timer_multi.sv
// timer_multi: NCH independent WIDTH-bit down-counting timers on the 8-bit 6502 bus.
// Each channel has a reload register, one-shot/periodic mode, an 8-bit prescaler,
// a sticky expiry flag (write 1 to clear) and an interrupt enable. The shared irq
// is the registered OR of flag & ie over all channels.
// Optional build macro TIMER_READ_LATCH_EN: a read of CNT byte 0 snapshots the
// whole counter so that bytes 1-3 read back consistently (tear-free).

// One timer channel: reload, prescaler, counter, flag and control bits.
module timer_multi_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,       // write strobe already decoded to this channel
  input  logic [2:0]       rsel,
  input  logic [7:0]       dbw,
  input  logic             snap,     // CNT byte 0 read: capture counter
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_hi,   // source for CNT bytes 1-3
  output logic             active,
  output logic             periodic,
  output logic             ie,
  output logic             flag,
  output logic [7:0]       pre,
  output logic             irq_nxt
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] reload;
  logic [7:0]       pcnt;
  logic             ctrl_wr, load, tick, expire, clr;
  logic             active_nxt, ie_nxt, flag_nxt;

  // Decode writes, tick and expiry; next-state of control bits and flag.
  always_comb begin
    ctrl_wr    = wr && (rsel == 3'd4);
    // Load on an inactive->active transition or an explicit load bit.
    load       = ctrl_wr && ((dbw[0] && !active) || dbw[3]);
    tick       = active && (pcnt == 8'd0);
    // A load overrides this cycle's tick, so it cannot expire.
    expire     = tick && (cnt == '0) && !load;
    clr        = wr && (rsel == 3'd5) && dbw[7];
    // Set beats a same-cycle W1C clear.
    flag_nxt   = expire || (flag && !clr);
    ie_nxt     = ctrl_wr ? dbw[2] : ie;
    active_nxt = active;
    if (ctrl_wr)
      active_nxt = dbw[0];
    else if (expire && !periodic)
      active_nxt = 1'b0;
    irq_nxt    = flag_nxt && ie_nxt;
  end

  // Counter and prescale count: load has priority, then tick, then prescale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      pcnt <= 8'd0;
    end else if (load) begin
      cnt  <= reload;
      pcnt <= pre;
    end else if (tick) begin
      pcnt <= pre;
      if (cnt != '0)
        cnt <= cnt - WIDTH'(1);
      else if (periodic)
        cnt <= reload;
    end else if (active) begin
      pcnt <= pcnt - 8'd1;
    end
  end

  // Bus-written configuration: control bits, prescale value, reload bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      pre      <= 8'd0;
      reload   <= '0;
    end else begin
      active <= active_nxt;
      ie     <= ie_nxt;
      if (ctrl_wr)
        periodic <= dbw[1];
      if (wr && (rsel == 3'd6))
        pre <= dbw;
      // Reload bytes beyond WIDTH simply have no storage.
      for (int n = 0; n < NB; n++)
        if (wr && (int'(rsel) == n))
          reload[8*n +: 8] <= dbw;
    end
  end

  // Sticky expiry flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flag <= 1'b0;
    else
      flag <= flag_nxt;
  end

`ifdef TIMER_READ_LATCH_EN
  logic [WIDTH-1:0] latch;

  // Snapshot of the counter taken when byte 0 is read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      latch <= '0;
    else if (snap)
      latch <= cnt;
  end

  assign cnt_hi = latch;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign cnt_hi      = cnt;
`endif

endmodule

// Top: address decode, channel array, registered read mux and irq.
module timer_multi #(
  parameter int NCH   = 2,
  parameter int WIDTH = 16,
  parameter int AW    = ((3 + $clog2(NCH)) < 4) ? 4 : (3 + $clog2(NCH))
) (
  input  logic          clk,
  input  logic          rst,
  output logic [7:0]    dbr,
  input  logic [7:0]    dbw,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic          re,
  output logic          irq
);
  logic [2:0]    rsel;
  logic [AW-4:0] csel;

  assign rsel = addr[2:0];
  assign csel = addr[AW-1:3];

  logic [NCH-1:0][WIDTH-1:0] cnt_a, hi_a;
  logic [NCH-1:0][7:0]       pre_a;
  logic [NCH-1:0]            act_a, per_a, ie_a, flag_a, irqn_a, wr_a, snap_a;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Channel select; channels at or above NCH never match.
    assign wr_a[i]   = we && (int'(csel) == i);
    assign snap_a[i] = re && (int'(csel) == i) && (rsel == 3'd0);

    timer_multi_ch #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_a[i]),
      .rsel     (rsel),
      .dbw      (dbw),
      .snap     (snap_a[i]),
      .cnt      (cnt_a[i]),
      .cnt_hi   (hi_a[i]),
      .active   (act_a[i]),
      .periodic (per_a[i]),
      .ie       (ie_a[i]),
      .flag     (flag_a[i]),
      .pre      (pre_a[i]),
      .irq_nxt  (irqn_a[i])
    );
  end

  logic [7:0]  rd_val;
  logic [31:0] byte_src;

  // Read mux; unmapped channels, bytes and reserved bits return 0.
  always_comb begin
    rd_val   = 8'h00;
    byte_src = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(csel) == i) begin
        // Byte 0 is always live; higher bytes may come from the snapshot.
        byte_src = (rsel == 3'd0) ? 32'(cnt_a[i]) : 32'(hi_a[i]);
        case (rsel)
          3'd0, 3'd1, 3'd2, 3'd3: rd_val = byte_src[{rsel[1:0], 3'b000} +: 8];
          3'd4:    rd_val = {5'b0, ie_a[i], per_a[i], act_a[i]};
          3'd5:    rd_val = {flag_a[i], 7'b0};
          3'd6:    rd_val = pre_a[i];
          default: rd_val = 8'h00;
        endcase
      end
    end
  end

  // Registered read data (held during writes) and shared level interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbr <= 8'h00;
      irq <= 1'b0;
    end else begin
      irq <= |irqn_a;
      if (!we)
        dbr <= rd_val;
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed checks of reset, one-shot, periodic/prescale,
// same-cycle set/clear, out-of-range decode and read latch, then random traffic
// checked against a closed-form model (ticks since load -> counter/flag).
`timescale 1ns/1ps
module tb_timer_multi;
  localparam int NCH = 2, WIDTH = 16, AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    dbr;
  logic [7:0]    dbw = 8'h00;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0, re = 1'b0;
  logic          irq;

  timer_multi #(.NCH(NCH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .dbr(dbr), .dbw(dbw), .addr(addr),
    .we(we), .re(re), .irq(irq)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the last posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered at a negedge and return at the next negedge.
  task automatic wr(input int a, input logic [7:0] d, output int e);
    addr = AW'(a); dbw = d; we = 1'b1; re = 1'b0; e = cyc + 1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] d, output int e);
    addr = AW'(a); we = 1'b0; re = 1'b1; e = cyc + 1;
    @(negedge clk);
    re = 1'b0; d = dbr;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // A programmed channel was loaded at edge mL with reload mR, prescale mP.
  // Tick j lands on edge mL + j*(mP+1); expiry ticks are multiples of mR+1.
  bit mProg[NCH], mPer[NCH], mIe[NCH];
  int mL[NCH], mR[NCH], mP[NCH], mW[NCH], mLat[NCH];

  function automatic int ticks(int c, int s);
    return (s - mL[c]) / (mP[c] + 1);
  endfunction

  function automatic int cnt_at(int c, int s);
    int n;
    if (!mProg[c]) return 0;
    n = ticks(c, s);
    if (mPer[c]) return mR[c] - (n % (mR[c] + 1));
    return (n <= mR[c]) ? mR[c] - n : 0;
  endfunction

  function automatic bit act_at(int c, int s);
    if (!mProg[c]) return 1'b0;
    return mPer[c] || (ticks(c, s) <= mR[c]);
  endfunction

  function automatic bit flag_at(int c, int s);
    int k, x;
    if (!mProg[c]) return 1'b0;
    k = ticks(c, s) / (mR[c] + 1);
    if (!mPer[c] && k > 1) k = 1;
    if (k == 0) return 1'b0;
    x = mL[c] + k * (mR[c] + 1) * (mP[c] + 1);
    return x >= mW[c];
  endfunction

  function automatic bit irq_at(int s);
    bit v = 1'b0;
    for (int c = 0; c < NCH; c++) v |= mIe[c] && flag_at(c, s);
    return v;
  endfunction

  function automatic logic [7:0] exp_read(int c, int r, int s);
    int v;
    if (c >= NCH) return 8'h00;
    v = cnt_at(c, s);
    case (r)
      0: return 8'(v);
`ifdef TIMER_READ_LATCH_EN
      1: return 8'(mLat[c] >> 8);
`else
      1: return 8'(v >> 8);
`endif
      4: return {5'b0, mIe[c], mPer[c], act_at(c, s)};
      5: return {flag_at(c, s), 7'b0};
      6: return 8'(mP[c]);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mProg[c] = 0; mPer[c] = 0; mIe[c] = 0;
      mL[c] = 0; mR[c] = 0; mP[c] = 0; mW[c] = 0; mLat[c] = 0;
    end
  endtask

  task automatic rd_chk(input int c, input int r);
    logic [7:0] d; int e; logic [7:0] x;
    rd(c * 8 + r, d, e);
    x = exp_read(c, r, e - 1);
`ifdef TIMER_READ_LATCH_EN
    if (c < NCH && r == 0) mLat[c] = cnt_at(c, e - 1);
`endif
    chk($sformatf("rd_c%0d_r%0d", c, r), 32'(d), 32'(x));
  endtask

  // Stop, clear, and reload a channel with random settings.
  task automatic program_ch(input int c);
    int r, p, e; bit per, ie;
    r   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(250, 300));
    p   = int'($urandom_range(0, 3));
    per = 1'($urandom_range(0, 1));
    ie  = 1'($urandom_range(0, 1));
    wr(c * 8 + 4, 8'h00, e); mIe[c] = 0;
    wr(c * 8 + 5, 8'h80, e); mW[c] = e;
    wr(c * 8 + 0, 8'(r), e);
    wr(c * 8 + 1, 8'(r >> 8), e);
    wr(c * 8 + 6, 8'(p), e);
    wr(c * 8 + 4, {4'b0000, 1'b1, ie, per, 1'b1}, e);
    mL[c] = e; mR[c] = r; mP[c] = p; mPer[c] = per; mIe[c] = ie; mProg[c] = 1;
  endtask

  // Watchdog: never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] d;
  int e, L, hit, op, a;

  initial begin
    model_reset();
    #2 rst = 1'b0;
    // Reset with random bus activity.
    repeat (6) begin
      @(negedge clk);
      chk("rst_dbr", 32'(dbr), 32'(0));
      chk("rst_irq", 32'(irq), 32'(0));
      we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      addr = AW'($urandom); dbw = 8'($urandom);
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0; rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd(i, d, e);
      chk($sformatf("rst_read_%0d", i), 32'(d), 32'(0));
    end
    chk("rst_irq_after", 32'(irq), 32'(0));

    // One-shot ch0: reload 5, PRE 0, CTRL=0x05 (load by 0->1).
    wr(0, 8'h05, e); wr(1, 8'h00, e);
    wr(4, 8'h05, L);
    hit = 0;
    for (int i = 0; i < 40 && hit == 0; i++) begin
      rd(5, d, e);
      if (d == 8'h80) hit = 1;
    end
    chk("os_expire_edge", 32'(e - 1), 32'(L + 6));
    chk("os_irq", 32'(irq), 32'(1));
    rd(0, d, e); chk("os_cnt_lo", 32'(d), 32'h00);
    rd(1, d, e); chk("os_cnt_hi", 32'(d), 32'h00);
    rd(4, d, e); chk("os_ctrl", 32'(d), 32'h04);
    wr(5, 8'h80, e);
    chk("os_irq_clr", 32'(irq), 32'(0));
    rd(5, d, e); chk("os_flag_clr", 32'(d), 32'h00);

    // Periodic ch1: reload 3, PRE 2, ie=0 -> 3,2,1,0,3 each held 3 clocks.
    wr(8, 8'h03, e); wr(9, 8'h00, e); wr(14, 8'h02, e);
    wr(12, 8'h03, L);
    for (int i = 0; i < 15; i++) begin
      rd(8, d, e);
      chk("per_cnt", 32'(d), 32'(3 - (((e - 1 - L) / 3) % 4)));
      chk("per_noirq", 32'(irq), 32'(0));
    end
    rd(13, d, e); chk("per_flag", 32'(d), 32'h80);
    wr(12, 8'h00, e); wr(13, 8'h80, e);

    // Same-cycle expiry and W1C on ch0: set wins.
    wr(0, 8'h02, e); wr(1, 8'h00, e);
    wr(4, 8'h0D, L);
    while (cyc + 1 < L + 3) @(negedge clk);
    wr(5, 8'h80, e);
    rd(5, d, e); chk("sc_flag", 32'(d), 32'h80);
    chk("sc_irq", 32'(irq), 32'(1));
    wr(5, 8'h80, e);
    chk("sc_irq_clr", 32'(irq), 32'(0));
    rd(5, d, e); chk("sc_flag_clr", 32'(d), 32'h00);

    // Out-of-range: reload byte 2/3 writes ignored; ch2/ch3 read 0.
    wr(0, 8'h04, e); wr(1, 8'h00, e); wr(2, 8'hFF, e); wr(3, 8'hFF, e);
    wr(4, 8'h0B, L);
    rd(0, d, e); chk("oor_cnt0", 32'(d), 32'h04);
    rd(2, d, e); chk("oor_byte2", 32'(d), 32'h00);
    while (cyc + 1 < L + 6) @(negedge clk);
    rd(0, d, e); chk("oor_wrap", 32'(d), 32'h04);
    rd(1, d, e); chk("oor_hi", 32'(d), 32'h00);
    rd(0, d, e); chk("oor_cnt2", 32'(d), 32'h02);
    rd(24, d, e); chk("oor_ch3", 32'(d), 32'h00);
    rd(19, d, e); chk("oor_ch2", 32'(d), 32'h00);
    wr(4, 8'h00, e);

    // Read latch: counter 0x0100, PRE 0.
    wr(0, 8'h00, e); wr(1, 8'h01, e);
    wr(4, 8'h09, L);
    rd(0, d, e); chk("lat_b0", 32'(d), 32'h00);
    idle(2);
    rd(1, d, e);
`ifdef TIMER_READ_LATCH_EN
    chk("lat_b1", 32'(d), 32'h01);
`else
    chk("lat_b1", 32'(d), 32'h00);
`endif
    wr(4, 8'h00, e);

    // Fresh reset, then randomized traffic against the model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    program_ch(0);
    program_ch(1);
    for (int s = 0; s < 30; s++) begin
      program_ch(int'($urandom_range(0, NCH - 1)));
      for (int k = 0; k < 15; k++) begin
        op = int'($urandom_range(0, 9));
        if (op <= 5) begin
          rd_chk(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 7)));
        end else if (op == 6) begin
          rd_chk(int'($urandom_range(2, 3)), int'($urandom_range(0, 7)));
        end else if (op == 7) begin
          if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
              0: a = 2;
              1: a = 3;
              default: a = 7;
            endcase
            a = a + 8 * int'($urandom_range(0, 1));
          end else begin
            a = int'($urandom_range(16, 31));
          end
          wr(a, 8'($urandom), e);
        end else if (op == 8) begin
          a = int'($urandom_range(0, NCH - 1));
          d = 8'($urandom);
          wr(a * 8 + 5, d, e);
          if (d[7]) mW[a] = e;
        end else begin
          idle(int'($urandom_range(0, 10)));
        end
        chk("rand_irq", 32'(irq), 32'(irq_at(cyc)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
